// File: rtl/wm_extraction.sv
// wm_extraction: recovers 2-bit watermark symbols from watermarked pixels.
// Each pixel's three candidate values (one per symbol) are rebuilt from the
// original neighbourhood pixels and blend factors, and the nearest candidate
// wins. Decoded symbols are packed four per byte, first symbol in [1:0].
// Optional feature macro: WM_EXTRACT_THRESH_EN (distance threshold check).
//
// Handshake: pix_valid is a one-way valid with no ready. A pixel is taken on
// every clock edge where pix_valid=1 and the FSM is in RUN; in every other
// state it is dropped. sym_valid and byte_valid are single-cycle pulses that
// the consumer must take on the cycle they assert (no backpressure).
module wm_extraction #(
  parameter int unsigned N_PIX  = 1024,
  parameter int unsigned THRESH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pix_valid,
  input  logic [7:0] wm_pix,
  input  logic [7:0] orig1,
  input  logic [7:0] orig2,
  input  logic [7:0] orig3,
  input  logic [7:0] a1,
  input  logic [7:0] a2,
  output logic       sym_valid,
  output logic [1:0] sym,
  output logic       sym_err,
  output logic       byte_valid,
  output logic [7:0] wm_byte,
  output logic       busy,
  output logic       done,
  output logic [1:0] state_dbg
);

  localparam int unsigned CNT_W = $clog2(N_PIX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] pix_cnt;
  logic             accept;
  logic             last_accept;
  logic             pipe_empty;
  logic             flush_emit;

  // stage 1 registers
  logic       s1_valid;
  logic [7:0] s1_wm, s1_o1, s1_o2, s1_a1, s1_a2, s1_base;
  logic [7:0] s1_half_nxt, s1_base_nxt;

  // stage 2 registers
  logic       s2_valid;
  logic [7:0] s2_wm, s2_p0, s2_p1, s2_p2;

  // stage 3 decision
  logic [7:0] d0, d1, d2, d_min;
  logic [1:0] sym_nxt;
  logic       err_nxt;

  // packer
  logic [1:0] slot;
  logic [5:0] sym_buf;

  assign accept      = (state == S_RUN) && pix_valid;
  assign last_accept = accept && (pix_cnt == CNT_W'(N_PIX - 1));
  assign pipe_empty  = !s1_valid && !s2_valid;
  assign flush_emit  = (state == S_FLUSH) && pipe_empty && (slot != 2'd0);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign state_dbg   = state;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state: frame runs until N_PIX accepts, then drains and reports
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_accept) state_nxt = S_FLUSH;
      S_FLUSH: if (pipe_empty && (slot == 2'd0)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // accepted-pixel counter for the current frame
  always_ff @(posedge clk) begin
    if (rst)                              pix_cnt <= '0;
    else if ((state == S_IDLE) && start)  pix_cnt <= '0;
    else if (accept)                      pix_cnt <= pix_cnt + 1'b1;
  end

  // stage 1 averaging: base = (((orig1+orig2)>>1) + orig3) >> 1
  always_comb begin
    s1_half_nxt = 8'((9'(orig1) + 9'(orig2)) >> 1);
    s1_base_nxt = 8'((9'(s1_half_nxt) + 9'(orig3)) >> 1);
  end

  // pipeline valid bits, cleared by reset so in-flight pixels are discarded
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
    end
  end

  // stage 1 data capture
  always_ff @(posedge clk) begin
    s1_wm   <= wm_pix;
    s1_o1   <= orig1;
    s1_o2   <= orig2;
    s1_a1   <= a1;
    s1_a2   <= a2;
    s1_base <= s1_base_nxt;
  end

  // stage 2 candidate rebuild, Q0.8 blend with 17-bit intermediates
  always_ff @(posedge clk) begin
    s2_wm <= s1_wm;
    s2_p0 <= s1_o1;
    s2_p1 <= 8'((17'(s1_a1) * 17'(s1_o1)
               + (17'd256 - 17'(s1_a1)) * 17'(s1_base)) >> 8);
    s2_p2 <= 8'((17'(s1_a2) * 17'(s1_o2)
               + (17'd256 - 17'(s1_a2)) * 17'(s1_base)) >> 8);
  end

  // stage 3 nearest-candidate selection; ties favour the lower symbol
  always_comb begin
    d0      = (s2_wm >= s2_p0) ? (s2_wm - s2_p0) : (s2_p0 - s2_wm);
    d1      = (s2_wm >= s2_p1) ? (s2_wm - s2_p1) : (s2_p1 - s2_wm);
    d2      = (s2_wm >= s2_p2) ? (s2_wm - s2_p2) : (s2_p2 - s2_wm);
    sym_nxt = 2'b00;
    d_min   = d0;
    err_nxt = 1'b0;
    if ((d0 <= d1) && (d0 <= d2)) begin
      sym_nxt = 2'b00;
      d_min   = d0;
    end else if (d1 <= d2) begin
      sym_nxt = 2'b01;
      d_min   = d1;
    end else begin
      sym_nxt = 2'b10;
      d_min   = d2;
    end
`ifdef WM_EXTRACT_THRESH_EN
    if (32'(d_min) > THRESH) begin
      err_nxt = 1'b1;
      sym_nxt = 2'b00;
    end
`endif
  end

  // stage 3 output register and symbol packer
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_valid  <= 1'b0;
      sym        <= 2'b00;
      sym_err    <= 1'b0;
      byte_valid <= 1'b0;
      wm_byte    <= 8'h00;
      slot       <= 2'd0;
      sym_buf    <= 6'd0;
    end else begin
      sym_valid  <= s2_valid;
      byte_valid <= 1'b0;
      if (s2_valid) begin
        sym     <= sym_nxt;
        sym_err <= err_nxt;
        if (slot == 2'd3) begin
          wm_byte    <= {sym_nxt, sym_buf};
          byte_valid <= 1'b1;
          slot       <= 2'd0;
          sym_buf    <= 6'd0;
        end else begin
          case (slot)
            2'd0:    sym_buf[1:0] <= sym_nxt;
            2'd1:    sym_buf[3:2] <= sym_nxt;
            default: sym_buf[5:4] <= sym_nxt;
          endcase
          slot <= slot + 2'd1;
        end
      end else if (flush_emit) begin
        // unfilled slots of the partial byte are zero because sym_buf is
        // cleared whenever a byte leaves
        wm_byte    <= {2'b00, sym_buf};
        byte_valid <= 1'b1;
        slot       <= 2'd0;
        sym_buf    <= 6'd0;
      end
    end
  end

endmodule

// File: tb/tb_wm_extraction.sv
// Bench for wm_extraction (N_PIX=6): directed frames from the test plan,
// mid-frame reset, ignored start/pix_valid, and randomized frames checked
// against an arithmetic reference model with cycle-stamped expectations.
module tb_wm_extraction;

  localparam int N         = 6;
  localparam int TB_THRESH = 8;

  logic       clk = 1'b0;
  logic       rst, start, pix_valid;
  logic [7:0] wm_pix, orig1, orig2, orig3, a1, a2;
  logic       sym_valid, sym_err, byte_valid, busy, done;
  logic [1:0] sym, state_dbg;
  logic [7:0] wm_byte;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0] wm, o1, o2, o3, a1, a2;
  } pix_t;
  typedef struct {
    int         cyc;
    logic [1:0] s;
    logic       e;
  } sym_exp_t;
  typedef struct {
    int         cyc;
    logic [7:0] b;
  } byte_exp_t;

  sym_exp_t   sym_q[$];
  byte_exp_t  byte_q[$];
  int         done_q[$];
  logic [7:0] got_bytes[$];
  logic [2:0] got_syms[$];
  pix_t       frame_q[$];
  pix_t       rp;

  wm_extraction #(.N_PIX(N), .THRESH(TB_THRESH)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid),
    .wm_pix(wm_pix), .orig1(orig1), .orig2(orig2), .orig3(orig3),
    .a1(a1), .a2(a2),
    .sym_valid(sym_valid), .sym(sym), .sym_err(sym_err),
    .byte_valid(byte_valid), .wm_byte(wm_byte),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // clock and cycle stamp
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference: rebuild candidates with plain integer math, pick nearest
  function automatic void ref_model(input pix_t p, output logic [1:0] s, output logic e);
    int base, w, best;
    int c[3];
    int d[3];
    base = (((int'(p.o1) + int'(p.o2)) / 2) + int'(p.o3)) / 2;
    c[0] = int'(p.o1);
    c[1] = (int'(p.a1) * int'(p.o1) + (256 - int'(p.a1)) * base) / 256;
    c[2] = (int'(p.a2) * int'(p.o2) + (256 - int'(p.a2)) * base) / 256;
    w = int'(p.wm);
    for (int k = 0; k < 3; k++) d[k] = (w > c[k]) ? (w - c[k]) : (c[k] - w);
    best = 0;
    for (int k = 1; k < 3; k++) if (d[k] < d[best]) best = k;
    s = 2'(best);
    e = 1'b0;
`ifdef WM_EXTRACT_THRESH_EN
    if (d[best] > TB_THRESH) begin
      e = 1'b1;
      s = 2'b00;
    end
`endif
  endfunction

  function automatic pix_t mk(input logic [7:0] w);
    pix_t p;
    p.wm = w; p.o1 = 8'd200; p.o2 = 8'd100; p.o3 = 8'd50;
    p.a1 = 8'd128; p.a2 = 8'd64;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input pix_t p);
    wm_pix = p.wm; orig1 = p.o1; orig2 = p.o2; orig3 = p.o3; a1 = p.a1; a2 = p.a2;
  endtask

  task automatic set_junk();
    wm_pix = 8'($urandom); orig1 = 8'($urandom); orig2 = 8'($urandom);
    orig3 = 8'($urandom); a1 = 8'($urandom); a2 = 8'($urandom);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every output pulse must match the front expectation and its cycle
  bit        mon_due;
  sym_exp_t  mon_se;
  byte_exp_t mon_be;
  always @(negedge clk) begin
    if (sym_valid === 1'b1) got_syms.push_back({sym, sym_err});
    if (byte_valid === 1'b1) got_bytes.push_back(wm_byte);

    mon_due = (sym_q.size() != 0) && (sym_q[0].cyc <= cyc);
    if (mon_due || sym_valid) begin
      tests++;
      assert (sym_valid === mon_due) else begin
        fails++;
        $error("FAIL sym_valid_timing cyc=%0d got=%b exp=%b", cyc, sym_valid, mon_due);
      end
      if (mon_due) begin
        mon_se = sym_q.pop_front();
        if (sym_valid) begin
          tests++;
          assert ({sym, sym_err} === {mon_se.s, mon_se.e}) else begin
            fails++;
            $error("FAIL sym_value cyc=%0d got=%b/%b exp=%b/%b", cyc, sym, sym_err, mon_se.s, mon_se.e);
          end
        end
      end
    end

    mon_due = (byte_q.size() != 0) && (byte_q[0].cyc <= cyc);
    if (mon_due || byte_valid) begin
      tests++;
      assert (byte_valid === mon_due) else begin
        fails++;
        $error("FAIL byte_valid_timing cyc=%0d got=%b exp=%b", cyc, byte_valid, mon_due);
      end
      if (mon_due) begin
        mon_be = byte_q.pop_front();
        if (byte_valid) begin
          tests++;
          assert (wm_byte === mon_be.b) else begin
            fails++;
            $error("FAIL byte_value cyc=%0d got=0x%0h exp=0x%0h", cyc, wm_byte, mon_be.b);
          end
        end
      end
    end

    mon_due = (done_q.size() != 0) && (done_q[0] <= cyc);
    if (mon_due || done) begin
      tests++;
      assert (done === mon_due) else begin
        fails++;
        $error("FAIL done_timing cyc=%0d got=%b exp=%b", cyc, done, mon_due);
      end
      if (mon_due) void'(done_q.pop_front());
    end
  end

  // runs one frame from frame_q and schedules every expected output
  task automatic run_frame(input int gap_max, input bit poke_start);
    logic [1:0] s;
    logic       e;
    logic [7:0] acc_byte;
    int         last_c;
    bit         seen;
    acc_byte = 8'h00;
    last_c   = 0;
    got_bytes.delete();
    got_syms.delete();
    // pixel presented with start must not be accepted
    start = 1'b1; pix_valid = 1'b1; set_junk();
    tick();
    start = 1'b0; pix_valid = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < N; i++) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
      set_pix(frame_q[i]);
      pix_valid = 1'b1;
      if (poke_start && i == 2) start = 1'b1;
      ref_model(frame_q[i], s, e);
      sym_q.push_back('{cyc + 3, s, e});
      acc_byte = acc_byte | ({6'd0, s} << (2 * (i % 4)));
      if (i % 4 == 3) begin
        byte_q.push_back('{cyc + 3, acc_byte});
        acc_byte = 8'h00;
      end
      last_c = cyc;
      tick();
      start = 1'b0; pix_valid = 1'b0;
    end
    if (N % 4 != 0) begin
      byte_q.push_back('{last_c + 4, acc_byte});
      done_q.push_back(last_c + 5);
    end else begin
      done_q.push_back(last_c + 4);
    end
    // surplus pixels after the frame is complete must be dropped
    pix_valid = 1'b1; set_junk();
    tick(); tick();
    pix_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (done === 1'b1) seen = 1'b1;
      else tick();
    end
    check("done_seen", 32'(seen), 32'd1);
    tick();
    check("busy_after_done", 32'(busy), 32'd0);
    repeat (4) tick();
    check("queues_drained", 32'(sym_q.size() + byte_q.size() + done_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pix_valid = 1'b0;
    wm_pix = 8'h00; orig1 = 8'h00; orig2 = 8'h00; orig3 = 8'h00; a1 = 8'h00; a2 = 8'h00;
    tick(); tick();
    check("reset_outputs",
          32'({sym_valid, sym, sym_err, byte_valid, wm_byte, busy, done}), 32'd0);

    // start together with rst: rst wins
    start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("start_with_rst", 32'(busy), 32'd0);
    tick();
    check("idle_after_rst", 32'(busy), 32'd0);

    // frame A: symbol decode, tie, packing 0x64, partial byte; start poked in RUN
    frame_q.delete();
    frame_q.push_back(mk(8'd200));
    frame_q.push_back(mk(8'd150));
    frame_q.push_back(mk(8'd101));
    frame_q.push_back(mk(8'd150));
    frame_q.push_back(mk(8'd175));
    frame_q.push_back(mk(8'd125));
    run_frame(0, 1'b1);
    check("a_sym_count", 32'(got_syms.size()), 32'd6);
    check("a_sym0_200", 32'(got_syms[0]), 32'b000);
    check("a_sym1_150", 32'(got_syms[1]), 32'b010);
    check("a_sym2_101", 32'(got_syms[2]), 32'b100);
    check("a_sym4_tie175", 32'(got_syms[4]), 32'b000);
`ifdef WM_EXTRACT_THRESH_EN
    check("a_sym5_125_err", 32'(got_syms[5]), 32'b001);
    check("a_byte1_partial", 32'(got_bytes[1]), 32'h00);
`else
    check("a_sym5_125", 32'(got_syms[5]), 32'b010);
    check("a_byte1_partial", 32'(got_bytes[1]), 32'h04);
`endif
    check("a_byte_count", 32'(got_bytes.size()), 32'd2);
    check("a_byte0", 32'(got_bytes[0]), 32'h64);

    // frame B: symbols 01,10,00,01,10,10 with gaps -> 0x49, 0x0A
    frame_q.delete();
    frame_q.push_back(mk(8'd150));
    frame_q.push_back(mk(8'd101));
    frame_q.push_back(mk(8'd200));
    frame_q.push_back(mk(8'd150));
    frame_q.push_back(mk(8'd101));
    frame_q.push_back(mk(8'd101));
    run_frame(2, 1'b0);
    check("b_byte_count", 32'(got_bytes.size()), 32'd2);
    check("b_byte0", 32'(got_bytes[0]), 32'h49);
    check("b_byte1", 32'(got_bytes[1]), 32'h0A);

    // reset after two accepts: everything cleared, no sym/byte/done afterwards
    start = 1'b1;
    tick();
    start = 1'b0;
    set_pix(mk(8'd150)); pix_valid = 1'b1;
    tick(); tick();
    pix_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_outputs",
          32'({sym_valid, sym, sym_err, byte_valid, wm_byte, busy, done}), 32'd0);
    repeat (8) tick();
    check("midrst_idle", 32'(busy), 32'd0);

    // randomized frames
    for (int f = 0; f < 4; f++) begin
      frame_q.delete();
      for (int i = 0; i < N; i++) begin
        rp.o1 = 8'($urandom); rp.o2 = 8'($urandom); rp.o3 = 8'($urandom);
        rp.a1 = 8'($urandom); rp.a2 = 8'($urandom);
        case ($urandom_range(0, 2))
          0:       rp.wm = 8'($urandom);
          1:       rp.wm = rp.o1;
          default: rp.wm = rp.o2 + 8'($urandom_range(0, 6));
        endcase
        frame_q.push_back(rp);
      end
      run_frame(f % 3, f[0]);
      check("rand_sym_count", 32'(got_syms.size()), 32'(N));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wm_extraction.md
# wm_extraction

Recovers the 2-bit watermark symbols that the insertion datapath embeds in image pixels. For each watermarked pixel it rebuilds the three candidate pixel values, one per symbol, from the original neighbourhood pixels and blend factors, then selects the nearest candidate. Decoded symbols are packed four per byte for the downstream watermark buffer. It sits on the verification/readback path, fed by the same pixel scheduler that drives insertion.

## Interface
Parameters:
- N_PIX, 1024, pixels per frame (≥1)
- THRESH, 8, max accepted distance between wm_pix and best candidate (used only with WM_EXTRACT_THRESH_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; begins a frame when the FSM is in IDLE
- pix_valid  in  1  wm_pix/orig*/a* are valid this cycle
- wm_pix  in  8  watermarked pixel
- orig1, orig2, orig3  in  8  original pixels Data1..Data3 used at insertion
- a1, a2  in  8  blend factors, unsigned Q0.8 (value/256)
- sym_valid  out  1  sym/sym_err valid
- sym  out  2  decoded symbol (00, 01, 10; 11 never produced)
- sym_err  out  1  best distance exceeded THRESH
- byte_valid  out  1  wm_byte valid
- wm_byte  out  8  four packed symbols, first symbol in [1:0]
- busy  out  1  FSM not IDLE
- done  out  1  one-cycle pulse at frame end

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE→RUN on start. pix_valid in IDLE is ignored.
  - RUN: accept each pix_valid and increment the pixel count. After the N_PIX-th accept, go to FLUSH. Further pix_valid is ignored. start in RUN/FLUSH/DONE is ignored.
  - FLUSH: wait until the pipeline is empty, emit any partial byte, then go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Pipeline stage 1 (registered):
  - s1 = (orig1+orig2)>>1, 9-bit sum, truncating.
  - base = (s1+orig3)>>1, truncating, 8-bit.
  - wm_pix, orig1, orig2, a1, a2 carried forward.
- Stage 2 (registered), unsigned, 17-bit intermediates, truncating:
  - P0 = orig1
  - P1 = (a1·orig1 + (256−a1)·base)>>8
  - P2 = (a2·orig2 + (256−a2)·base)>>8
- Stage 3 (registered output):
  - dk = |wm_pix − Pk|, 8-bit.
  - sym = index of min dk; ties resolve 00 > 01 > 10.
- Packer: 2-bit slot counter.
  - Each sym_valid writes sym into slot [2k+1:2k].
  - On slot 3, wm_byte/byte_valid assert in the same cycle as that sym_valid, and the slot counter wraps to 0.
  - In FLUSH, a nonzero slot count emits wm_byte with empty slots = 00, byte_valid one cycle, then clears the counter.

## Timing
- Latency: pix_valid at cycle T → sym_valid at T+3. Full throughput, one pixel per cycle; no backpressure.
- FLUSH lasts 3 cycles after the last accept, plus 1 cycle if a partial byte is emitted.
- done asserts the cycle after the last byte_valid (or after the last sym_valid if there is no partial byte).
- Reset values: sym_valid=0, sym=00, sym_err=0, byte_valid=0, wm_byte=00, busy=0, done=0. FSM=IDLE, counters=0, pipeline valids cleared.
- rst mid-frame: everything is cleared on the next edge; in-flight pixels are discarded and no done is produced.
- start coinciding with rst: rst wins.
- pix_valid in the same cycle as start: not accepted; accept begins the next cycle.

## Configuration
- WM_EXTRACT_THRESH_EN defined:
  - Stage 3 compares the min distance with THRESH.
  - If min > THRESH: sym_err=1 and sym forced to 00; the packer stores 00.
- Undefined: no comparator; sym_err tied 0; THRESH unused.

## Test plan
- Frame setup for the first four scenarios: N_PIX=4; orig1=200, orig2=100, orig3=50 (base=100); a1=128, a2=64 → P0=200, P1=150, P2=100.
- wm_pix=150 → sym=01 at T+3, sym_err=0. wm_pix=200 → 00. wm_pix=101 → 10.
- Tie: wm_pix=175 (d0=d1=25) → sym=00. With macro and THRESH=8: wm_pix=125 (d1=d2=25) → sym_err=1, sym=00; without macro → sym=01, sym_err=0.
- Packing: 4-pixel stream with wm_pix 200,150,101,150 → byte_valid with wm_byte=0x64 coincident with the 4th sym_valid; done one cycle later; busy then 0.
- Partial byte: N_PIX=6, symbols 01,10,00,01,10,10 → bytes 0x49 then 0x0A (in FLUSH); done after the second byte.
- Mid-frame: assert rst after 2 accepts → all outputs 0 the next cycle, no byte/done. A start in RUN is ignored and the count is unaffected. pix_valid after N_PIX accepts produces no sym_valid.
